// File: rtl/div_unit_pkg.sv
// Shared divider types: FSM state encoding and default operand width.
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider handshake: operands, start/annul request, result/ready.
interface div_unit_if #(parameter int DATA_W = 32);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// result_o = {remainder, quotient}; ready_o stays up until start_i drops.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DATA_W);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q;   // partial remainder
  logic [DATA_W-1:0] dvd_q;   // dividend shifts out of the top, quotient bits shift in
  logic [DATA_W-1:0] dvs_q;   // divisor magnitude
  logic              neg1_q, neg2_q, sgn_q;

  logic [DATA_W:0]   step;
  logic [DATA_W-1:0] abs1, abs2, q_fix, r_fix;
  logic              accept;

  // One restoring iteration: returns {quotient bit, new partial remainder}.
  // The shifted value is < 2*divisor, so a 33-bit difference is always in range.
  function automatic logic [DATA_W:0] div_step(input logic [DATA_W-1:0] rem,
                                               input logic              msb,
                                               input logic [DATA_W-1:0] dvs);
    logic [DATA_W:0] sh, diff;
    sh   = {rem, msb};
    diff = sh - {1'b0, dvs};
    if (diff[DATA_W]) div_step = {1'b0, sh[DATA_W-1:0]};
    else              div_step = {1'b1, diff[DATA_W-1:0]};
  endfunction

  // Operand magnitudes, iteration step and final sign fix-up.
  always_comb begin
    abs1   = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    abs2   = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
    accept = bus.start_i && !bus.annul_i;
    step   = div_step(rem_q, dvd_q[DATA_W-1], dvs_q);
    q_fix  = (sgn_q && (neg1_q ^ neg2_q)) ? -dvd_q : dvd_q;
    r_fix  = (sgn_q && neg1_q) ? -rem_q : rem_q;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_FREE:    if (accept) state_d = (bus.opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
      DIV_BY_ZERO: state_d = DIV_END;
      DIV_ON: begin
        if (bus.annul_i)           state_d = DIV_FREE;
        else if (cnt_q == CNT_END) state_d = DIV_END;
      end
      DIV_END:     if (!bus.start_i) state_d = DIV_FREE;
      default:     state_d = DIV_FREE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DIV_FREE;
    else     state_q <= state_d;
  end

  // Datapath: operand latch, iterations, registered result/ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      rem_q        <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      neg1_q       <= 1'b0;
      neg2_q       <= 1'b0;
      sgn_q        <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= 1'b0;
    end else begin
      case (state_q)
        DIV_FREE: begin
          bus.result_o <= '0;
          bus.ready_o  <= 1'b0;
          if (accept && bus.opdata2_i != '0) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            dvd_q  <= abs1;
            dvs_q  <= abs2;
            neg1_q <= bus.opdata1_i[DATA_W-1];
            neg2_q <= bus.opdata2_i[DATA_W-1];
            sgn_q  <= bus.signed_div_i;
          end
        end
        DIV_BY_ZERO: begin
          bus.result_o <= '0;
          bus.ready_o  <= 1'b1;
        end
        DIV_ON: begin
          if (bus.annul_i) begin
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
          end else if (cnt_q != CNT_END) begin
            rem_q <= step[DATA_W-1:0];
            dvd_q <= {dvd_q[DATA_W-2:0], step[DATA_W]};
            cnt_q <= cnt_q + 1'b1;
          end else begin
            bus.result_o <= {r_fix, q_fix};
            bus.ready_o  <= 1'b1;
          end
        end
        DIV_END: begin
          if (!bus.start_i) begin
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized divides
// compared against a plain-arithmetic reference.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: signed uses 64-bit truncating division (covers the
  // 0x80000000 / -1 wrap), unsigned uses plain unsigned arithmetic.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  // Advance one cycle at a time until ready_o, bounded; n = edges seen.
  task automatic wait_ready(input int limit, input bit scramble, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (scramble && n == 1) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom_range(0, 1));
      end
      if (bus.ready_o) break;
    end
  endtask

  // Full transaction: start, latency, result, hold stability, release.
  task automatic do_div(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int n;
    exp = ref_div(s, a, b);
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    wait_ready(60, 1'b1, n);
    chk({tag, " latency"}, 65'(n), (b == 0) ? 65'd2 : 65'd34);
    chk({tag, " result"}, {bus.ready_o, bus.result_o}, {1'b1, exp});
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk({tag, " hold"}, {bus.ready_o, bus.result_o}, {1'b1, exp});
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " release"}, {bus.ready_o, bus.result_o}, 65'd0);
  endtask

  initial begin
    int n;
    bit seen;
    logic [31:0] a, b;
    bit s;

    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {bus.ready_o, bus.result_o}, 65'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div("divu 100/7", 1'b0, 32'd100, 32'd7);
    do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    do_div("divu ffffffff/10", 1'b0, 32'hFFFF_FFFF, 32'h10);
    do_div("div by zero s", 1'b1, 32'd1234, 32'd0);
    do_div("div by zero u", 1'b0, 32'hDEAD_BEEF, 32'd0);
    do_div("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div("divu 5/9", 1'b0, 32'd5, 32'd9);
    do_div("divu 0/3", 1'b0, 32'd0, 32'd3);

    // Annul in the 10th DivOn cycle: no result, then a clean divide.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("annul outputs", {bus.ready_o, bus.result_o}, 65'd0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      seen |= bus.ready_o;
    end
    chk("annul no ready", 65'(seen), 65'd0);
    do_div("after annul 100/7", 1'b0, 32'd100, 32'd7);

    // annul_i with start_i in DivFree: nothing accepted; releasing annul starts it.
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      seen |= bus.ready_o;
    end
    chk("annul+start ignored", 65'(seen), 65'd0);
    bus.annul_i = 1'b0;
    wait_ready(60, 1'b0, n);
    chk("annul release latency", 65'(n), 65'd34);
    chk("annul release result", {bus.ready_o, bus.result_o}, {1'b1, ref_div(1'b0, 32'd100, 32'd7)});
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Asynchronous reset mid-DivOn, start held so it restarts afterwards.
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'hFFFF_FF9C;   // -100
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1 rst = 1'b1;
    #1 chk("rst mid divide", {bus.ready_o, bus.result_o}, 65'd0);
    #1 rst = 1'b0;
    wait_ready(60, 1'b0, n);
    chk("after rst latency", 65'(n), 65'd34);
    chk("after rst result", {bus.ready_o, bus.result_o}, {1'b1, ref_div(1'b1, 32'hFFFF_FF9C, 32'd7)});

    // Asynchronous reset while holding a finished result.
    #1 rst = 1'b1;
    #1 chk("rst in DivEnd", {bus.ready_o, bus.result_o}, 65'd0);
    bus.start_i = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);

    // Randomized divides with biased divisors.
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        3:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      do_div($sformatf("rand%0d", i), s, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
